// File: rtl/reg_op_ctrl_if.sv
// rtl/reg_op_ctrl_if.sv - command handshake and regfile port bundle for reg_op_ctrl
// master = the sequencer side, slave = command source plus register file.
interface reg_op_ctrl_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_rd;
  logic [AW-1:0] cmd_rs1;
  logic [AW-1:0] cmd_rs2;
  logic [AW-1:0] ra;
  logic [AW-1:0] rb;
  logic [DW-1:0] busa;
  logic [DW-1:0] busb;
  logic [AW-1:0] rw;
  logic [DW-1:0] busw;
  logic          we;

  modport master (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, busa, busb,
    output cmd_ready, ra, rb, rw, busw, we
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, busa, busb,
    input  cmd_ready, ra, rb, rw, busw, we
  );
endinterface

// File: rtl/reg_op_ctrl.sv
// rtl/reg_op_ctrl.sv - ALU/CLEAR command sequencer in front of a 32-entry register file
// Optional REGOP_R0_ZERO_EN: register 0 is hardwired zero (never written, skipped by CLEAR).
module reg_op_ctrl #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_op_ctrl_if.master bus,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          result_zero
);

  typedef enum logic [2:0] {IDLE, READ, EXEC, WRITE, CLEAR} state_t;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_OR    = 3'd3;
  localparam logic [2:0] OP_XOR   = 3'd4;
  localparam logic [2:0] OP_MOV   = 3'd5;
  localparam logic [2:0] OP_SLTU  = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  localparam logic [AW-1:0] CNT_LAST = '1;
`ifdef REGOP_R0_ZERO_EN
  localparam logic [AW-1:0] CNT_FIRST = AW'(1);
`else
  localparam logic [AW-1:0] CNT_FIRST = '0;
`endif

  state_t        state, state_nxt;
  logic [2:0]    op_q;
  logic [AW-1:0] rd_q, rs1_q, rs2_q, cnt;
  logic [DW-1:0] opa, opb, alu_q, alu_nxt;
  logic [AW-1:0] rw_hold;
  logic [DW-1:0] busw_hold;
  logic          accept;
  logic          rd_writable;
  logic          clear_last;

  assign accept     = bus.cmd_valid && bus.cmd_ready;
  assign clear_last = (state == CLEAR) && (cnt == CNT_LAST);

`ifdef REGOP_R0_ZERO_EN
  assign rd_writable = (rd_q != '0);
`else
  assign rd_writable = 1'b1;
`endif

  // Read addresses come straight from the latched sources; only READ cares.
  assign bus.ra      = rs1_q;
  assign bus.rb      = rs2_q;
  assign result_zero = (result == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // we is decoded from state so an asynchronous reset drops it at once.
  always_comb begin
    state_nxt     = state;
    bus.cmd_ready = 1'b0;
    busy          = 1'b1;
    bus.we        = 1'b0;
    bus.rw        = rw_hold;
    bus.busw      = busw_hold;
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        busy          = 1'b0;
        if (bus.cmd_valid) state_nxt = (bus.cmd_op == OP_CLEAR) ? CLEAR : READ;
      end
      READ: state_nxt = EXEC;
      EXEC: state_nxt = WRITE;
      WRITE: begin
        bus.we    = rd_writable;
        bus.rw    = rd_q;
        bus.busw  = alu_q;
        state_nxt = IDLE;
      end
      CLEAR: begin
        bus.we   = 1'b1;
        bus.rw   = cnt;
        bus.busw = '0;
        if (cnt == CNT_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    alu_nxt = '0;
    case (op_q)
      OP_ADD:  alu_nxt = opa + opb;
      OP_SUB:  alu_nxt = opa - opb;
      OP_AND:  alu_nxt = opa & opb;
      OP_OR:   alu_nxt = opa | opb;
      OP_XOR:  alu_nxt = opa ^ opb;
      OP_MOV:  alu_nxt = opa;
      OP_SLTU: alu_nxt = {{(DW-1){1'b0}}, (opa < opb)};
      default: alu_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      cnt       <= '0;
      opa       <= '0;
      opb       <= '0;
      alu_q     <= '0;
      rw_hold   <= '0;
      busw_hold <= '0;
      done      <= 1'b0;
      result    <= '0;
    end else begin
      rw_hold   <= bus.rw;
      busw_hold <= bus.busw;
      if (accept) begin
        op_q  <= bus.cmd_op;
        rd_q  <= bus.cmd_rd;
        rs1_q <= bus.cmd_rs1;
        rs2_q <= bus.cmd_rs2;
        cnt   <= CNT_FIRST;
      end
      if (state == READ) begin
        opa <= bus.busa;
        opb <= bus.busb;
      end
      if (state == EXEC)  alu_q <= alu_nxt;
      if (state == CLEAR) cnt   <= cnt + AW'(1);
      done <= (state == WRITE) || clear_last;
      if (state == WRITE)   result <= alu_q;
      else if (clear_last)  result <= '0;
    end
  end

endmodule
